// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: flit encodings, arbiter state type and the round-robin pick helper.
package noc_arb_pkg;
   localparam int MAX_PORTS = 32;
   localparam int IDX_W = $clog2(MAX_PORTS);
   typedef enum logic [2:0] {HEAD_ID = 3'b001, TAIL_ID = 3'b100} flit_id_t;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   typedef struct packed {
      logic found;
      logic [IDX_W-1:0] idx;
   } pick_t;
   // Searches ptr+1, ptr+2, ... with wrap; descending loop leaves the nearest hit in r.
   function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] mask, input int ptr, input int n);
      pick_t r;
      int j;
      r = '0;
      for (int k = MAX_PORTS; k >= 1; k--)
         if (k <= n) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (mask[j]) begin
               r.found = 1'b1;
               r.idx = j[IDX_W-1:0];
            end
         end
      return r;
   endfunction
endpackage

// File: rtl/rr_timeout_arbiter_if.sv
// rr_timeout_arbiter_if: request/flit inputs and grant/timeout outputs of the arbiter.
//  master drives req/flit_id/length and observes grant*/timeout*; slave is the arbiter side.
interface rr_timeout_arbiter_if #(
   parameter int NUM_PORTS = 5,
   parameter int LEN_W = 12,
   parameter int FLIT_ID_W = 3
);
   localparam int PTR_W = $clog2(NUM_PORTS);
   logic [NUM_PORTS-1:0] req;
   logic [NUM_PORTS*FLIT_ID_W-1:0] flit_id;
   logic [NUM_PORTS*LEN_W-1:0] length;
   logic [NUM_PORTS-1:0] grant;
   logic grant_valid;
   logic [PTR_W-1:0] grant_idx;
   logic timeout;
   logic [PTR_W-1:0] timeout_idx;
   modport master (
      output req, flit_id, length,
      input grant, grant_valid, grant_idx, timeout, timeout_idx
   );
   modport slave (
      input req, flit_id, length,
      output grant, grant_valid, grant_idx, timeout, timeout_idx
   );
endinterface

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: per-input timeout limits (loaded on head flits) and the shared hold counter.
//  in: clk, rst, flit_id, length, grant_idx, new_grant, holding; out: timesup.
module arb_timeout_counter
   import noc_arb_pkg::*;
#(
   parameter int NUM_PORTS = 5,
   parameter int LEN_W = 12,
   parameter int FLIT_ID_W = 3
) (
   input logic clk,
   input logic rst,
   input logic [NUM_PORTS*FLIT_ID_W-1:0] flit_id,
   input logic [NUM_PORTS*LEN_W-1:0] length,
   input logic [$clog2(NUM_PORTS)-1:0] grant_idx,
   input logic new_grant,
   input logic holding,
   output logic timesup
);
   logic [LEN_W-1:0] limit [NUM_PORTS];
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] lim;
   always_ff @(posedge clk)
      if (rst) begin
         for (int i = 0; i < NUM_PORTS; i++) limit[i] <= '0;
         cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++)
            if (flit_id[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(HEAD_ID)) limit[i] <= length[i*LEN_W +: LEN_W];
         cnt <= new_grant ? '0 : holding ? cnt + LEN_W'(1) : cnt;
      end
   assign lim = limit[grant_idx];
   // >= rather than == so a limit lowered mid-grant below cnt still fires.
   assign timesup = (lim != '0) && (cnt >= lim - LEN_W'(1));
endmodule

// File: rtl/rr_timeout_arbiter.sv
// rr_timeout_arbiter: round-robin arbiter with per-input packet timeout for a NoC output port.
//  in: clk, rst, bus.req/flit_id/length; out: bus.grant/grant_valid/grant_idx/timeout/timeout_idx.
module rr_timeout_arbiter
   import noc_arb_pkg::*;
#(
   parameter int NUM_PORTS = 5,
   parameter int LEN_W = 12,
   parameter int FLIT_ID_W = 3
) (
   input logic clk,
   input logic rst,
   rr_timeout_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_PORTS);
   arb_state_t state, state_n;
   logic [PTR_W-1:0] idx, idx_n, ptr, ptr_n, to_idx, to_idx_n;
   logic to, to_n, timesup, hold, new_grant;
   logic [NUM_PORTS-1:0] cand;
   pick_t pk;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         ptr <= PTR_W'(NUM_PORTS - 1);
         to <= 1'b0;
         to_idx <= '0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         ptr <= ptr_n;
         to <= to_n;
         to_idx <= to_idx_n;
      end
   // The current owner is excluded on release so a timed-out input cannot be regranted back-to-back.
   always_comb begin
      hold = (state == GRANT) && bus.req[idx] && !timesup;
      cand = (state == GRANT) ? bus.req & ~(NUM_PORTS'(1) << idx) : bus.req;
      pk = rr_pick(MAX_PORTS'(cand), int'(ptr), NUM_PORTS);
      new_grant = !hold && pk.found;
      state_n = (hold || pk.found) ? GRANT : IDLE;
      idx_n = new_grant ? pk.idx[PTR_W-1:0] : idx;
      ptr_n = new_grant ? pk.idx[PTR_W-1:0] : ptr;
      to_n = (state == GRANT) && bus.req[idx] && timesup;
      to_idx_n = to_n ? idx : to_idx;
   end
   always_comb begin
      bus.grant = (state == GRANT) ? NUM_PORTS'(1) << idx : '0;
      bus.grant_valid = state == GRANT;
      bus.grant_idx = idx;
      bus.timeout = to;
      bus.timeout_idx = to_idx;
   end
   arb_timeout_counter #(
      .NUM_PORTS(NUM_PORTS),
      .LEN_W(LEN_W),
      .FLIT_ID_W(FLIT_ID_W)
   ) u_cnt (
      .clk(clk),
      .rst(rst),
      .flit_id(bus.flit_id),
      .length(bus.length),
      .grant_idx(idx),
      .new_grant(new_grant),
      .holding(hold),
      .timesup(timesup)
   );
endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// tb_rr_timeout_arbiter: directed scenarios plus random traffic checked against a behavioural model.
module tb_rr_timeout_arbiter;
   localparam int N = 5;
   localparam int L = 12;
   localparam int F = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   rr_timeout_arbiter_if #(.NUM_PORTS(N), .LEN_W(L), .FLIT_ID_W(F)) bus ();
   rr_timeout_arbiter #(.NUM_PORTS(N), .LEN_W(L), .FLIT_ID_W(F)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   int checks = 0;
   int errors = 0;
   int m_own = -1;
   int m_idx = 0;
   int m_ptr = N - 1;
   int m_cnt = 0;
   int m_to = 0;
   int m_to_idx = 0;
   int m_lim [N];
   int to_seen;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic set_heads(input logic [N-1:0] hm, input int len);
      for (int i = 0; i < N; i++) begin
         bus.flit_id[i*F +: F] = hm[i] ? 3'b001 : 3'b010;
         bus.length[i*L +: L] = L'(len);
      end
   endtask
   // Reference: who owns the port, how long it has held it, and the limits seen on head flits.
   task automatic model_edge();
      logic [N-1:0] r;
      bit ts;
      int w;
      int j;
      r = bus.req;
      if (rst) begin
         m_own = -1; m_idx = 0; m_ptr = N - 1; m_cnt = 0; m_to = 0; m_to_idx = 0;
         for (int i = 0; i < N; i++) m_lim[i] = 0;
         return;
      end
      ts = (m_own >= 0) && (m_lim[m_own] != 0) && (m_cnt + 1 >= m_lim[m_own]);
      m_to = 0;
      if (m_own >= 0 && r[m_own] && !ts) m_cnt = (m_cnt + 1) % (1 << L);
      else begin
         if (m_own >= 0 && r[m_own]) begin
            m_to = 1;
            m_to_idx = m_own;
         end
         w = -1;
         for (int k = N; k >= 1; k--) begin
            j = (m_ptr + k) % N;
            if (r[j] && j != m_own) w = j;
         end
         m_own = w;
         m_cnt = 0;
         if (w >= 0) begin
            m_idx = w;
            m_ptr = w;
         end
      end
      for (int i = 0; i < N; i++)
         if (bus.flit_id[i*F +: F] == 3'b001) m_lim[i] = int'(bus.length[i*L +: L]);
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("grant", 32'(bus.grant), m_own >= 0 ? 32'd1 << m_own : 32'd0);
      check("grant_valid", 32'(bus.grant_valid), 32'(m_own >= 0));
      check("grant_idx", 32'(bus.grant_idx), 32'(m_idx));
      check("timeout", 32'(bus.timeout), 32'(m_to));
      if (m_to != 0) check("timeout_idx", 32'(bus.timeout_idx), 32'(m_to_idx));
   endtask
   initial begin
      logic [N-1:0] hm;
      bus.req = '0;
      set_heads('0, 0);
      rst = 1'b1;
      step();
      step();
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_timeout_idx", 32'(bus.timeout_idx), 32'd0);
      check("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
      rst = 1'b0;
      // limit 0: held indefinitely
      bus.req = 5'b00001;
      step();
      check("t1_first", 32'(bus.grant), 32'h1);
      to_seen = 0;
      repeat (100) begin
         step();
         to_seen += int'(bus.timeout);
      end
      check("t1_no_timeout", 32'(to_seen), 32'd0);
      check("t1_still", 32'(bus.grant), 32'h1);
      // limit 4 on port 0
      bus.req = '0;
      step();
      set_heads(5'b00001, 4);
      step();
      set_heads('0, 0);
      bus.req = 5'b00001;
      for (int k = 0; k < 4; k++) begin
         step();
         check("t2_hold", 32'(bus.grant), 32'h1);
      end
      step();
      check("t2_to", 32'(bus.timeout), 32'd1);
      check("t2_to_idx", 32'(bus.timeout_idx), 32'd0);
      check("t2_idle", 32'(bus.grant_valid), 32'd0);
      step();
      check("t2_regrant", 32'(bus.grant), 32'h1);
      // all limits 2, everyone requesting; ptr is now 0 so port 1 leads
      bus.req = '0;
      step();
      set_heads(5'b11111, 2);
      step();
      set_heads('0, 0);
      bus.req = 5'b11111;
      for (int k = 0; k < 10; k++) begin
         step();
         check("t3_rot", 32'(bus.grant_idx), 32'((1 + k / 2) % N));
         check("t3_nobubble", 32'(bus.grant_valid), 32'd1);
         check("t3_pulse", 32'(bus.timeout), 32'(k > 0 && k % 2 == 0));
      end
      // drop without timeout, RR wrap from port 2
      bus.req = '0;
      step();
      set_heads(5'b11111, 0);
      step();
      set_heads('0, 0);
      bus.req = 5'b00100;
      step();
      step();
      bus.req = 5'b01001;
      step();
      check("t4_idx", 32'(bus.grant_idx), 32'd3);
      check("t4_no_to", 32'(bus.timeout), 32'd0);
      // lower the limit below cnt mid-grant
      bus.req = '0;
      step();
      bus.req = 5'b00010;
      step();
      repeat (6) step();
      set_heads(5'b00010, 3);
      step();
      set_heads('0, 0);
      step();
      check("t5_to", 32'(bus.timeout), 32'd1);
      check("t5_to_idx", 32'(bus.timeout_idx), 32'd1);
      // reset mid-grant
      bus.req = '0;
      step();
      bus.req = 5'b00100;
      step();
      step();
      rst = 1'b1;
      step();
      check("t6_rst_grant", 32'(bus.grant), 32'd0);
      check("t6_rst_to", 32'(bus.timeout), 32'd0);
      rst = 1'b0;
      bus.req = 5'b11111;
      step();
      check("t6_first", 32'(bus.grant_idx), 32'd0);
      // random traffic
      repeat (3000) begin
         bus.req = N'($urandom);
         for (int i = 0; i < N; i++) begin
            hm[i] = $urandom_range(0, 3) == 0;
            bus.flit_id[i*F +: F] = hm[i] ? 3'b001 : 3'(($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100);
            bus.length[i*L +: L] = L'($urandom_range(0, 6));
         end
         rst = $urandom_range(0, 199) == 0;
         step();
      end
      rst = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
